// File: rtl/iram_init_pkg.sv
// Shared types and constants for the CoreABC instruction RAM boot loader.
package iram_init_pkg;

  localparam int unsigned RAM_DEPTH = 512;
  localparam int unsigned WORD_W    = 9;
  localparam int unsigned ADDR_W    = 9;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_COUNT   = 2'b01;
  localparam logic [1:0] ERR_DATA    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SYNC,
    ST_CNT_LO,
    ST_CNT_HI,
    ST_DATA_LO,
    ST_DATA_HI,
    ST_CHECK,
    ST_DONE,
    ST_ERR
  } load_state_e;

  // States in which the loader offers IN_READY.
  function automatic logic is_accepting(input load_state_e s);
    return s inside {ST_SYNC, ST_CNT_LO, ST_CNT_HI, ST_DATA_LO, ST_DATA_HI, ST_CHECK};
  endfunction

  // States in which a stalled source is timed; sync hunting may wait forever.
  function automatic logic is_timed(input load_state_e s);
    return s inside {ST_CNT_LO, ST_CNT_HI, ST_DATA_LO, ST_DATA_HI, ST_CHECK};
  endfunction

endpackage

// File: rtl/iram_init_timer.sv
// Idle timer for the boot loader: down-counter reloaded on clear, flags expiry
// once TIMEOUT enabled cycles have passed without a clear.
module iram_init_timer #(
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [15:0] RELOAD = 16'(TIMEOUT - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Reload on clear, otherwise count down to zero while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = RELOAD;
    end else if (en && (cnt_q != 16'd0)) begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en && !clr && (cnt_q == 16'd0);

endmodule

// File: rtl/iram_init_loader.sv
// Boot loader for the 512x9 CoreABC instruction RAM: parses a framed byte
// stream, writes 9-bit words to consecutive addresses and checks a checksum.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | after reset, waiting for START
// SYNC     | hunting for the sync byte, other bytes discarded
// CNT_LO   | expecting word count low byte
// CNT_HI   | expecting word count high byte, count range checked
// DATA_LO  | expecting low byte of a word
// DATA_HI  | expecting high byte of a word, write issued
// CHECK    | expecting checksum byte
// DONE     | image loaded, INITDONE held until START
// ERR      | load failed, INITERR/ERRCODE held until START
module iram_init_loader
  import iram_init_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT,
  parameter int unsigned TIMEOUT   = 4096
) (
  input  logic              PCLK,
  input  logic              NSYSRESET,
  input  logic              START,
  input  logic              IN_VALID,
  input  logic [7:0]        IN_DATA,
  output logic              IN_READY,
  output logic [ADDR_W-1:0] INITADDR,
  output logic [WORD_W-1:0] INITDATA,
  output logic              WENABLE,
  output logic              INITDONE,
  output logic              INITERR,
  output logic [1:0]        ERRCODE
);

  localparam logic [15:0] MAX_WORDS = 16'(RAM_DEPTH);

  load_state_e       state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [ADDR_W-1:0] initaddr_q, initaddr_d;
  logic [WORD_W-1:0] initdata_q, initdata_d;
  logic              wenable_q, wenable_d;
  logic              initdone_q, initdone_d;
  logic              initerr_q, initerr_d;
  logic [1:0]        errcode_q, errcode_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        csum_q, csum_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [7:0]        lo_q, lo_d;

  logic        accept;
  logic        last_word;
  logic        tmr_run;
  logic        tmr_clr;
  logic        tmr_expired;
  logic        fail;
  logic [1:0]  fail_code;
  logic [15:0] count_w;

  assign accept    = IN_VALID && in_ready_q;
  assign last_word = (({7'd0, addr_q}) + 16'd1) == cnt_q;
  assign tmr_run   = is_timed(state_q);
  assign tmr_clr   = accept || !tmr_run;

  iram_init_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (PCLK),
    .rst_n   (NSYSRESET),
    .clr     (tmr_clr),
    .en      (tmr_run),
    .expired (tmr_expired)
  );

  // Next-state and datapath decode for the frame parser.
  always_comb begin
    state_d    = state_q;
    initaddr_d = initaddr_q;
    initdata_d = initdata_q;
    wenable_d  = 1'b0;
    initdone_d = initdone_q;
    initerr_d  = initerr_q;
    errcode_d  = errcode_q;
    addr_d     = addr_q;
    csum_d     = csum_q;
    cnt_d      = cnt_q;
    lo_d       = lo_q;
    fail       = 1'b0;
    fail_code  = ERR_NONE;
    count_w    = {IN_DATA, cnt_q[7:0]};

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (START) begin
          state_d    = ST_SYNC;
          initdone_d = 1'b0;
          initerr_d  = 1'b0;
          errcode_d  = ERR_NONE;
          addr_d     = '0;
          csum_d     = '0;
        end
      end
      ST_SYNC: begin
        if (accept && (IN_DATA == SYNC_BYTE)) begin
          state_d = ST_CNT_LO;
        end
      end
      ST_CNT_LO: begin
        if (accept) begin
          cnt_d[7:0] = IN_DATA;
          state_d    = ST_CNT_HI;
        end
      end
      ST_CNT_HI: begin
        if (accept) begin
          cnt_d = count_w;
          if ((count_w == 16'd0) || (count_w > MAX_WORDS)) begin
            fail      = 1'b1;
            fail_code = ERR_COUNT;
          end else begin
            state_d = ST_DATA_LO;
          end
        end
      end
      ST_DATA_LO: begin
        if (accept) begin
          lo_d    = IN_DATA;
          csum_d  = csum_q + IN_DATA;
          state_d = ST_DATA_HI;
        end
      end
      ST_DATA_HI: begin
        if (accept) begin
          if (IN_DATA[7:1] != 7'd0) begin
            fail      = 1'b1;
            fail_code = ERR_DATA;
          end else begin
            csum_d     = csum_q + IN_DATA;
            initaddr_d = addr_q;
            initdata_d = {IN_DATA[0], lo_q};
            wenable_d  = 1'b1;
            addr_d     = addr_q + 9'd1;
            state_d    = last_word ? ST_CHECK : ST_DATA_LO;
          end
        end
      end
      ST_CHECK: begin
        if (accept) begin
          if (IN_DATA == csum_q) begin
            state_d    = ST_DONE;
            initdone_d = 1'b1;
          end else begin
            fail      = 1'b1;
            fail_code = ERR_DATA;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The timer only expires in cycles with no accepted byte, so it never
    // competes with a byte-driven decision above.
    if (tmr_expired) begin
      fail      = 1'b1;
      fail_code = ERR_TIMEOUT;
    end

    if (fail) begin
      state_d   = ST_ERR;
      initerr_d = 1'b1;
      errcode_d = fail_code;
    end

    in_ready_d = is_accepting(state_d);
  end

  // State, status and RAM-port registers; reset aborts any load in flight.
  always_ff @(posedge PCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      state_q    <= ST_IDLE;
      in_ready_q <= 1'b0;
      initaddr_q <= '0;
      initdata_q <= '0;
      wenable_q  <= 1'b0;
      initdone_q <= 1'b0;
      initerr_q  <= 1'b0;
      errcode_q  <= ERR_NONE;
      addr_q     <= '0;
      csum_q     <= '0;
      cnt_q      <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      initaddr_q <= initaddr_d;
      initdata_q <= initdata_d;
      wenable_q  <= wenable_d;
      initdone_q <= initdone_d;
      initerr_q  <= initerr_d;
      errcode_q  <= errcode_d;
      addr_q     <= addr_d;
      csum_q     <= csum_d;
      cnt_q      <= cnt_d;
      lo_q       <= lo_d;
    end
  end

  assign IN_READY = in_ready_q;
  assign INITADDR = initaddr_q;
  assign INITDATA = initdata_q;
  assign WENABLE  = wenable_q;
  assign INITDONE = initdone_q;
  assign INITERR  = initerr_q;
  assign ERRCODE  = errcode_q;

endmodule

// File: tb/tb_iram_init_loader.sv
// Directed bench for iram_init_loader with a frame-level reference model.
module tb_iram_init_loader;

  localparam int TMO = 8;

  logic       PCLK = 1'b0;
  logic       NSYSRESET;
  logic       START = 1'b0;
  logic       IN_VALID = 1'b0;
  logic [7:0] IN_DATA = 8'h00;
  logic       IN_READY;
  logic [8:0] INITADDR;
  logic [8:0] INITDATA;
  logic       WENABLE;
  logic       INITDONE;
  logic       INITERR;
  logic [1:0] ERRCODE;

  always #5 PCLK = ~PCLK;

  iram_init_loader #(
    .SYNC_BYTE (8'hA5),
    .TIMEOUT   (TMO)
  ) dut (
    .PCLK      (PCLK),
    .NSYSRESET (NSYSRESET),
    .START     (START),
    .IN_VALID  (IN_VALID),
    .IN_DATA   (IN_DATA),
    .IN_READY  (IN_READY),
    .INITADDR  (INITADDR),
    .INITDATA  (INITDATA),
    .WENABLE   (WENABLE),
    .INITDONE  (INITDONE),
    .INITERR   (INITERR),
    .ERRCODE   (ERRCODE)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail < 40)
        $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Frame-level model: position within the frame decides what a byte means.
  bit         m_load = 0;
  bit         m_hunt = 0;
  bit         m_done = 0;
  bit         m_err  = 0;
  bit         m_we   = 0;
  logic [1:0] m_code = 2'b00;
  int         m_pos  = 0;
  int         m_n    = 0;
  int         m_idle = 0;
  logic [7:0] m_nlo  = 8'h00;
  logic [7:0] m_lo   = 8'h00;
  logic [7:0] m_sum  = 8'h00;
  logic [8:0] m_wa   = 9'h000;
  logic [8:0] m_wd   = 9'h000;
  int         cyc    = 0;
  int         last_acc = 0;
  bit         cmp_en = 0;

  task automatic m_fail(input logic [1:0] code);
    m_err  = 1;
    m_code = code;
    m_load = 0;
  endtask

  task automatic consume(input logic [7:0] b);
    int idx;
    if (m_hunt) begin
      if (b == 8'hA5) begin
        m_hunt = 0;
        m_pos  = 0;
      end
    end else begin
      if (m_pos == 0) begin
        m_nlo = b;
      end else if (m_pos == 1) begin
        m_n = int'(b) * 256 + int'(m_nlo);
        if (m_n == 0 || m_n > 512) m_fail(2'b01);
      end else if (m_pos < 2 + 2 * m_n) begin
        idx = m_pos - 2;
        if (idx % 2 == 0) begin
          m_lo  = b;
          m_sum = m_sum + b;
        end else if (b > 8'd1) begin
          m_fail(2'b10);
        end else begin
          m_sum = m_sum + b;
          m_we  = 1;
          m_wa  = 9'(idx / 2);
          m_wd  = {b[0], m_lo};
        end
      end else begin
        if (b == m_sum) begin
          m_done = 1;
          m_load = 0;
        end else begin
          m_fail(2'b10);
        end
      end
      m_pos++;
    end
  endtask

  // Model update on each clock, reset forces everything idle immediately.
  always @(posedge PCLK or negedge NSYSRESET) begin
    if (NSYSRESET !== 1'b1) begin
      m_load = 0; m_hunt = 0; m_done = 0; m_err = 0; m_we = 0;
      m_code = 2'b00; m_pos = 0; m_idle = 0; m_sum = 8'h00;
    end else begin
      cyc++;
      m_we = 0;
      if (m_load) begin
        if (IN_VALID) begin
          m_idle   = 0;
          last_acc = cyc;
          consume(IN_DATA);
        end else if (!m_hunt) begin
          m_idle++;
          if (m_idle >= TMO) m_fail(2'b11);
        end
      end else if (START) begin
        m_load = 1; m_hunt = 1; m_done = 0; m_err = 0; m_code = 2'b00;
        m_pos = 0; m_sum = 8'h00; m_idle = 0;
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge PCLK) begin
    if (cmp_en) begin
      chk("in_ready", 16'(IN_READY), 16'(m_load));
      chk("wenable", 16'(WENABLE), 16'(m_we));
      if (m_we) begin
        chk("initaddr", 16'(INITADDR), 16'(m_wa));
        chk("initdata", 16'(INITDATA), 16'(m_wd));
      end
      chk("initdone", 16'(INITDONE), 16'(m_done));
      chk("initerr", 16'(INITERR), 16'(m_err));
      chk("errcode", 16'(ERRCODE), 16'(m_code));
    end
  end

  // Write log for literal checks.
  logic [8:0] log_a[$];
  logic [8:0] log_d[$];
  always @(negedge PCLK) begin
    if (WENABLE === 1'b1) begin
      log_a.push_back(INITADDR);
      log_d.push_back(INITDATA);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge PCLK);
    IN_VALID = 1'b1;
    IN_DATA  = b;
    while (IN_READY !== 1'b1 && t < 40) begin
      @(negedge PCLK);
      t++;
    end
    if (IN_READY !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL ready_wait: IN_READY=%b after %0d cycles, expected 1", IN_READY, t);
    end
    @(posedge PCLK);
  endtask

  task automatic send_seq(input logic [7:0] q[$]);
    foreach (q[i]) send_byte(q[i]);
  endtask

  task automatic idle_bus();
    @(negedge PCLK);
    IN_VALID = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge PCLK);
    START = 1'b1;
    @(negedge PCLK);
    START = 1'b0;
    log_a.delete();
    log_d.delete();
  endtask

  task automatic wait_end(input string name);
    int t;
    t = 0;
    while (INITDONE !== 1'b1 && INITERR !== 1'b1 && t < 100) begin
      @(negedge PCLK);
      t++;
    end
    chk(name, 16'(INITDONE === 1'b1 || INITERR === 1'b1), 16'd1);
    repeat (2) @(negedge PCLK);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"}, 16'(IN_READY), 16'd0);
    chk({tag, "_initaddr"}, 16'(INITADDR), 16'd0);
    chk({tag, "_initdata"}, 16'(INITDATA), 16'd0);
    chk({tag, "_wenable"},  16'(WENABLE),  16'd0);
    chk({tag, "_initdone"}, 16'(INITDONE), 16'd0);
    chk({tag, "_initerr"},  16'(INITERR),  16'd0);
    chk({tag, "_errcode"},  16'(ERRCODE),  16'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    logic [7:0] sum;
    logic [8:0] w;
    int t;

    NSYSRESET = 1'b0;
    repeat (3) @(negedge PCLK);
    check_reset_values("reset");
    cmp_en = 1'b1;
    #1 NSYSRESET = 1'b1;

    // Frame A, START held only during the cycle DONE is entered.
    pulse_start();
    q = '{8'hA5, 8'h03, 8'h00, 8'h12, 8'h00, 8'h34, 8'h01, 8'hFF, 8'h00};
    send_seq(q);
    @(negedge PCLK);
    IN_VALID = 1'b1;
    IN_DATA  = 8'h46;
    START    = 1'b1;
    @(posedge PCLK);
    @(negedge PCLK);
    IN_VALID = 1'b0;
    START    = 1'b0;
    repeat (3) @(negedge PCLK);
    chk("a_writes", 16'(log_a.size()), 16'd3);
    if (log_a.size() == 3) begin
      chk("a_addr0", 16'(log_a[0]), 16'h000); chk("a_data0", 16'(log_d[0]), 16'h012);
      chk("a_addr1", 16'(log_a[1]), 16'h001); chk("a_data1", 16'(log_d[1]), 16'h134);
      chk("a_addr2", 16'(log_a[2]), 16'h002); chk("a_data2", 16'(log_d[2]), 16'h0FF);
    end
    chk("a_done", 16'(INITDONE), 16'd1);
    chk("a_err", 16'(INITERR), 16'd0);
    chk("a_ready_low", 16'(IN_READY), 16'd0);

    // Garbage before sync, one word.
    pulse_start();
    q = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'h7F, 8'h01, 8'h80};
    send_seq(q);
    idle_bus();
    wait_end("hunt_end");
    chk("hunt_writes", 16'(log_a.size()), 16'd1);
    if (log_a.size() == 1) begin
      chk("hunt_addr", 16'(log_a[0]), 16'h000);
      chk("hunt_data", 16'(log_d[0]), 16'h17F);
    end
    chk("hunt_done", 16'(INITDONE), 16'd1);

    // Count zero.
    pulse_start();
    q = '{8'hA5, 8'h00, 8'h00};
    send_seq(q);
    idle_bus();
    wait_end("cnt0_end");
    chk("cnt0_err", 16'(INITERR), 16'd1);
    chk("cnt0_code", 16'(ERRCODE), 16'd1);
    chk("cnt0_writes", 16'(log_a.size()), 16'd0);

    // Count 513.
    pulse_start();
    q = '{8'hA5, 8'h01, 8'h02};
    send_seq(q);
    idle_bus();
    wait_end("cnt513_end");
    chk("cnt513_done", 16'(INITDONE), 16'd0);
    chk("cnt513_err", 16'(INITERR), 16'd1);
    chk("cnt513_code", 16'(ERRCODE), 16'd1);
    chk("cnt513_writes", 16'(log_a.size()), 16'd0);

    // Bad high byte in word 0.
    pulse_start();
    q = '{8'hA5, 8'h02, 8'h00, 8'h05, 8'h02};
    send_seq(q);
    idle_bus();
    wait_end("hib_end");
    chk("hib_err", 16'(INITERR), 16'd1);
    chk("hib_code", 16'(ERRCODE), 16'd2);
    chk("hib_writes", 16'(log_a.size()), 16'd0);

    // Wrong checksum (correct value would be 34).
    pulse_start();
    q = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h00, 8'h22, 8'h01, 8'h00};
    send_seq(q);
    idle_bus();
    wait_end("csum_end");
    chk("csum_writes", 16'(log_a.size()), 16'd2);
    if (log_a.size() == 2) begin
      chk("csum_data0", 16'(log_d[0]), 16'h011);
      chk("csum_data1", 16'(log_d[1]), 16'h122);
    end
    chk("csum_err", 16'(INITERR), 16'd1);
    chk("csum_code", 16'(ERRCODE), 16'd2);

    // Stall after the count bytes.
    pulse_start();
    q = '{8'hA5, 8'h01, 8'h00};
    send_seq(q);
    idle_bus();
    t = 0;
    while (INITERR !== 1'b1 && t < 50) begin
      @(negedge PCLK);
      t++;
    end
    chk("tmo_latency", 16'(cyc - last_acc), 16'd8);
    chk("tmo_code", 16'(ERRCODE), 16'd3);

    // Reload after the timeout.
    pulse_start();
    q = '{8'hA5, 8'h03, 8'h00, 8'h12, 8'h00, 8'h34, 8'h01, 8'hFF, 8'h00, 8'h46};
    send_seq(q);
    idle_bus();
    wait_end("reload_end");
    chk("reload_done", 16'(INITDONE), 16'd1);
    chk("reload_err", 16'(INITERR), 16'd0);
    chk("reload_code", 16'(ERRCODE), 16'd0);
    chk("reload_writes", 16'(log_a.size()), 16'd3);

    // Reset after 100 of 512 words.
    pulse_start();
    q = '{8'hA5, 8'h00, 8'h02};
    send_seq(q);
    for (int i = 0; i < 100; i++) begin
      w = 9'((i * 37 + 5) % 512);
      send_byte(w[7:0]);
      send_byte({7'd0, w[8]});
    end
    #3;
    NSYSRESET = 1'b0;
    IN_VALID  = 1'b0;
    #1;
    check_reset_values("midrst");
    chk("midrst_writes", 16'(log_a.size()), 16'd99);
    @(negedge PCLK);
    #1 NSYSRESET = 1'b1;

    // Full 512-word load.
    pulse_start();
    q = '{8'hA5, 8'h00, 8'h02};
    sum = 8'h00;
    for (int i = 0; i < 512; i++) begin
      w = 9'((i * 37 + 5) % 512);
      q.push_back(w[7:0]);
      q.push_back({7'd0, w[8]});
      sum = sum + w[7:0] + {7'd0, w[8]};
    end
    q.push_back(sum);
    send_seq(q);
    idle_bus();
    wait_end("full_end");
    chk("full_writes", 16'(log_a.size()), 16'd512);
    if (log_a.size() == 512) begin
      chk("full_last_addr", 16'(log_a[511]), 16'd511);
      chk("full_last_data", 16'(log_d[511]), 16'((511 * 37 + 5) % 512));
    end
    chk("full_done", 16'(INITDONE), 16'd1);
    chk("full_err", 16'(INITERR), 16'd0);

    repeat (3) @(negedge PCLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/iram_init_loader.md
# iram_init_loader

- Sits directly upstream of the 512x9 CoreABC instruction RAM and drives its initialisation write port (INITADDR, INITDATA, WENABLE).
- Accepts a framed byte stream from a boot source (flash reader or UART) over a valid/ready handshake.
- Unpacks byte pairs into 9-bit instruction words, writes them to consecutive RAM addresses and checks a frame checksum.
- Reports done/error status so the system can hold the processor in reset until the program image is loaded.

## Interface
Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT, 4096, maximum PCLK cycles between accepted bytes during a load. Legal range 2..65535.

Ports:
- PCLK  in  1  single clock.
- NSYSRESET  in  1  asynchronous, active-low reset.
- START  in  1  level-sampled load request.
- IN_VALID  in  1  byte valid.
- IN_DATA  in  8  stream byte.
- IN_READY  out  1  loader accepts the byte this cycle.
- INITADDR  out  9  RAM write address.
- INITDATA  out  9  RAM write data.
- WENABLE  out  1  one-cycle RAM write strobe.
- INITDONE  out  1  image loaded and checksum good. Sticky.
- INITERR  out  1  load failed. Sticky.
- ERRCODE  out  2  cause of failure: 01 bad count, 10 bad high byte / checksum, 11 timeout.

## Operation
- A byte is accepted when IN_VALID and IN_READY are both high on a rising PCLK edge.
- IN_READY is high only in SYNC, CNT_LO, CNT_HI, DATA_LO, DATA_HI and CHECK. It is low in IDLE, DONE and ERR.
- Frame format:
  - SYNC_BYTE.
  - Word count N, low byte then high byte.
  - N word pairs: low byte = word[7:0], high byte with bit0 = word[8] and bits[7:1] = 0.
  - One checksum byte = 8-bit sum, modulo 256, of all 2N data bytes.
- FSM states: IDLE, SYNC, CNT_LO, CNT_HI, DATA_LO, DATA_HI, CHECK, DONE, ERR.
- IDLE: START=1 moves to SYNC. This also clears INITDONE, INITERR and ERRCODE, and zeroes the address counter and checksum.
- SYNC: a byte not equal to SYNC_BYTE is discarded and the FSM stays in SYNC (hunt). A byte equal to SYNC_BYTE moves to CNT_LO.
- CNT_LO → CNT_HI: capture the 16-bit count.
  - N=0 or N>512 → ERR with code 01.
  - Otherwise → DATA_LO.
- DATA_LO: latch the low byte and add it to the checksum.
- DATA_HI:
  - bits[7:1] ≠ 0 → ERR with code 10.
  - Otherwise add the byte to the checksum and issue a write.
  - If this was word N → CHECK, else → DATA_LO.
- CHECK: byte equal to the running checksum → DONE (INITDONE=1). Mismatch → ERR with code 10.
- DONE / ERR: START=1 restarts the sequence exactly as from IDLE.
- START is ignored while a load is in progress (SYNC through CHECK).
- Timeout:
  - The idle counter runs in every accepting state except SYNC.
  - It resets on each accepted byte.
  - When it reaches TIMEOUT-1 with no byte accepted → ERR with code 11.
- Address arithmetic: the 9-bit counter starts at 0 and increments after each write. N ≤ 512 guarantees no wrap; address 511 is the last possible write.

## Timing
- Reset values: IN_READY=0, INITADDR=0, INITDATA=0, WENABLE=0, INITDONE=0, INITERR=0, ERRCODE=00, FSM=IDLE.
- Reset asserted mid-load aborts immediately. Any write not yet strobed is lost.
- WENABLE pulses for exactly one cycle, the cycle after the high byte is accepted. INITADDR and INITDATA are registered and stable in that same cycle.
- Back-to-back bytes are supported at one per cycle, so consecutive words can produce WENABLE every 2 cycles.
- INITDONE / INITERR rise the cycle after the deciding byte is accepted.
- When the error is a bad high byte, no WENABLE is issued for that word.
- START seen in the same cycle that DONE is entered has no effect; it takes effect from the DONE state on a later cycle.
- Zero-latency handshake: IN_READY does not depend on IN_VALID combinationally.

## Structure
- Shared package iram_init_pkg holds:
  - the state enumeration;
  - ERRCODE constants (ERR_NONE, ERR_COUNT, ERR_DATA, ERR_TIMEOUT);
  - RAM depth 512 and word width 9;
  - default SYNC_BYTE.
- One sub-module, iram_init_timer: loadable idle counter with clear, enable and expiry flag, parameterised by TIMEOUT.
- FSM, checksum and address counter stay in the top level.

## Test plan
- Frame A5 03 00 | 12 00 34 01 FF 00 | checksum 46: three WENABLE pulses writing addr0=0x012, addr1=0x134, addr2=0x0FF, then INITDONE=1, INITERR=0.
- Garbage 00 FF before A5 with a 1-word frame: the garbage is discarded and the load completes normally, with the write at addr0.
- Count 00 00, then separately count 01 02 (N=513): INITERR=1 and ERRCODE=01 in both cases, with no WENABLE.
- High byte 0x02 in word 0: INITERR=1, ERRCODE=10, zero writes. A separate run with a wrong checksum byte gives all writes done, then INITERR=1, ERRCODE=10.
- TIMEOUT=8 and the stream stalls after CNT_HI: ERRCODE=11 exactly 8 cycles after the last accepted byte. START then reloads a good frame to INITDONE=1.
- NSYSRESET asserted after 100 of 512 words: all outputs go to reset values immediately. A restarted full 512-word load ends with the last write at INITADDR=511 and INITDONE=1.
